// File: rtl/pipe_stage_buf_pkg.sv
// Shared types for the elastic inter-stage pipeline register.
package pipe_stage_buf_pkg;

  localparam int PS_XLEN = 64;

  typedef logic [PS_XLEN-1:0] dw_t;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } ps_state_e;

endpackage

// File: rtl/pipe_entry_reg.sv
// Payload register {pc, data} with load and clear enables; clear zeroes only the
// low CLR_W bits so the head can keep its PC across a flush.
module pipe_entry_reg
  import pipe_stage_buf_pkg::*;
#(
  parameter int W     = 8,
  parameter int CLR_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clear_i) begin
      q_d[CLR_W-1:0] = '0;
    end else if (load_i) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline boundary: head + skid entries behind a valid/ready handshake,
// with flush, stall and a saturating count of cycles without a valid output.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int XLEN          = PS_XLEN,
  parameter int NUM_CH        = 3,
  parameter int PC_W          = 64,
  parameter int CNT_W         = 16,
  parameter bit ZERO_ON_FLUSH = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   stall,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PC_W-1:0]        in_pc,
  input  logic [NUM_CH*XLEN-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W-1:0]        out_pc,
  output logic [NUM_CH*XLEN-1:0] out_data,
  output logic [1:0]             occupancy,
  output logic [CNT_W-1:0]       bubble_cnt
);

  localparam int DW = NUM_CH * XLEN;
  localparam int EW = PC_W + DW;

  ps_state_e        state_q, state_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic [EW-1:0]    head_q, skid_q, head_src;
  logic             acc_w, rel_w, head_load, skid_load, clr_w;

  assign in_ready  = !stall && !flush && (state_q != PS_TWO);
  assign out_valid = (state_q != PS_EMPTY) && !stall && !flush;
  assign acc_w     = in_valid && in_ready;
  assign rel_w     = out_valid && out_ready;

  // Head refills from the skid when draining TWO, otherwise straight from the input.
  assign head_src  = (state_q == PS_TWO) ? skid_q : {in_pc, in_data};
  assign head_load = (acc_w && (state_q == PS_EMPTY || rel_w)) ||
                     (rel_w && state_q == PS_TWO);
  assign skid_load = acc_w && !rel_w && (state_q == PS_ONE);
  assign clr_w     = flush && ZERO_ON_FLUSH;

  pipe_entry_reg #(.W(EW), .CLR_W(DW)) u_head (
    .clk     (clk),
    .rst     (rst),
    .load_i  (head_load),
    .clear_i (clr_w),
    .d_i     (head_src),
    .q_o     (head_q)
  );

  pipe_entry_reg #(.W(EW), .CLR_W(DW)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .clear_i (clr_w),
    .d_i     ({in_pc, in_data}),
    .q_o     (skid_q)
  );

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = PS_EMPTY;
    end else begin
      case (state_q)
        PS_EMPTY: if (acc_w) state_d = PS_ONE;
        PS_ONE: begin
          if (acc_w && !rel_w)      state_d = PS_TWO;
          else if (rel_w && !acc_w) state_d = PS_EMPTY;
        end
        PS_TWO:   if (rel_w) state_d = PS_ONE;
        default:  state_d = PS_EMPTY;
      endcase
    end
  end

  always_comb begin
    bubble_d = bubble_q;
    if (!out_valid && (bubble_q != {CNT_W{1'b1}})) begin
      bubble_d = bubble_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= PS_EMPTY;
      bubble_q <= '0;
    end else begin
      state_q  <= state_d;
      bubble_q <= bubble_d;
    end
  end

  assign out_pc     = head_q[EW-1:DW];
  assign out_data   = head_q[DW-1:0];
  assign occupancy  = state_q;
  assign bubble_cnt = bubble_q;

  a_no_ready_in_two: assert property (@(posedge clk) disable iff (rst)
    !(in_ready && state_q == PS_TWO));

  a_head_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> $stable(out_data));

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed-vector bench for pipe_stage_buf: default build plus a narrow
// CNT_W=4 / NUM_CH=1 / XLEN=32 / ZERO_ON_FLUSH=0 build driven in lockstep.
module tb_pipe_stage_buf;

  typedef struct {
    logic        fl, st, iv, ordy;
    logic [63:0] pc;
    logic        ov, ir;
    logic [1:0]  occ;
    logic [63:0] opc;
    logic        dz1, dz2;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst, flush, stall, in_valid, out_ready;
  logic [63:0]  in_pc;
  logic [191:0] in_data;
  logic [31:0]  in_data2;

  logic         in_ready1, out_valid1;
  logic [63:0]  out_pc1;
  logic [191:0] out_data1;
  logic [1:0]   occ1;
  logic [15:0]  bub1;

  logic         in_ready2, out_valid2;
  logic [63:0]  out_pc2;
  logic [31:0]  out_data2;
  logic [1:0]   occ2;
  logic [3:0]   bub2;

  int errors = 0;
  int checks = 0;
  int bmod1  = 0;
  int bmod2  = 0;

  vec_t vt[24];

  assign in_data2 = in_data[31:0];

  always #5 clk = ~clk;

  pipe_stage_buf dut1 (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(in_ready1), .in_pc(in_pc), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_pc(out_pc1), .out_data(out_data1),
    .occupancy(occ1), .bubble_cnt(bub1)
  );

  pipe_stage_buf #(.XLEN(32), .NUM_CH(1), .PC_W(64), .CNT_W(4), .ZERO_ON_FLUSH(1'b0)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(in_ready2), .in_pc(in_pc), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready), .out_pc(out_pc2), .out_data(out_data2),
    .occupancy(occ2), .bubble_cnt(bub2)
  );

  function automatic logic [191:0] mkd(input logic [63:0] p);
    return {p ^ 64'hA5A5_0000_0000_0003, ~p, p + 64'h1234};
  endfunction

  function automatic vec_t v(input logic fl, st, iv, ordy, input logic [63:0] pc,
                             input logic ov, ir, input logic [1:0] occ,
                             input logic [63:0] opc, input logic dz1, dz2);
    vec_t r;
    r.fl = fl; r.st = st; r.iv = iv; r.ordy = ordy; r.pc = pc;
    r.ov = ov; r.ir = ir; r.occ = occ; r.opc = opc; r.dz1 = dz1; r.dz2 = dz2;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, fl, st, iv, ordy, input logic [63:0] pc);
    rst = r; flush = fl; stall = st; in_valid = iv; out_ready = ordy;
    in_pc = pc; in_data = mkd(pc);
  endtask

  task automatic bump(input logic ov);
    if (!ov) begin
      if (bmod1 < 65535) bmod1++;
      if (bmod2 < 15)    bmod2++;
    end
  endtask

  initial begin
    logic [191:0] e1;
    logic [191:0] t2;
    logic [31:0]  e2;

    vt[0]  = v(0,0,0,0,64'h0,   0,1,0,64'h0,  1,1);
    vt[1]  = v(0,0,0,0,64'h0,   0,1,0,64'h0,  1,1);
    vt[2]  = v(0,0,1,1,64'h100, 0,1,0,64'h0,  1,1);
    vt[3]  = v(0,0,1,1,64'h104, 1,1,1,64'h100,0,0);
    vt[4]  = v(0,0,1,1,64'h108, 1,1,1,64'h104,0,0);
    vt[5]  = v(0,0,0,1,64'h0,   1,1,1,64'h108,0,0);
    vt[6]  = v(0,0,0,0,64'h0,   0,1,0,64'h108,0,0);
    vt[7]  = v(0,0,1,0,64'h200, 0,1,0,64'h108,0,0);
    vt[8]  = v(0,0,1,0,64'h204, 1,1,1,64'h200,0,0);
    vt[9]  = v(0,0,1,0,64'h208, 1,0,2,64'h200,0,0);
    vt[10] = v(0,0,0,1,64'h0,   1,0,2,64'h200,0,0);
    vt[11] = v(0,0,0,1,64'h0,   1,1,1,64'h204,0,0);
    vt[12] = v(0,0,0,0,64'h0,   0,1,0,64'h204,0,0);
    vt[13] = v(0,0,1,0,64'h280, 0,1,0,64'h204,0,0);
    vt[14] = v(0,0,1,0,64'h284, 1,1,1,64'h280,0,0);
    vt[15] = v(1,0,1,0,64'h300, 0,0,2,64'h280,0,0);
    vt[16] = v(0,0,0,1,64'h0,   0,1,0,64'h280,1,0);
    vt[17] = v(0,0,1,0,64'h400, 0,1,0,64'h280,1,0);
    vt[18] = v(0,1,1,1,64'h404, 0,0,1,64'h400,0,0);
    vt[19] = v(0,1,1,1,64'h404, 0,0,1,64'h400,0,0);
    vt[20] = v(0,1,1,1,64'h404, 0,0,1,64'h400,0,0);
    vt[21] = v(0,0,0,0,64'h0,   1,1,1,64'h400,0,0);
    vt[22] = v(1,1,1,1,64'h408, 0,0,1,64'h400,0,0);
    vt[23] = v(0,0,0,0,64'h0,   0,1,0,64'h400,1,0);

    drive(1, 0, 0, 0, 0, 64'h0);
    repeat (2) @(posedge clk);

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      drive(0, vt[i].fl, vt[i].st, vt[i].iv, vt[i].ordy, vt[i].pc);
      #1;
      e1 = vt[i].dz1 ? '0 : mkd(vt[i].opc);
      t2 = mkd(vt[i].opc);
      e2 = vt[i].dz2 ? 32'h0 : t2[31:0];
      chk($sformatf("r%0d_ov1", i),  out_valid1, vt[i].ov);
      chk($sformatf("r%0d_ir1", i),  in_ready1,  vt[i].ir);
      chk($sformatf("r%0d_occ1", i), occ1,       vt[i].occ);
      chk($sformatf("r%0d_pc1", i),  out_pc1,    vt[i].opc);
      chk($sformatf("r%0d_dat1", i), out_data1,  e1);
      chk($sformatf("r%0d_bub1", i), bub1,       bmod1);
      chk($sformatf("r%0d_ov2", i),  out_valid2, vt[i].ov);
      chk($sformatf("r%0d_occ2", i), occ2,       vt[i].occ);
      chk($sformatf("r%0d_pc2", i),  out_pc2,    vt[i].opc);
      chk($sformatf("r%0d_dat2", i), out_data2,  e2);
      chk($sformatf("r%0d_bub2", i), bub2,       bmod2);
      bump(vt[i].ov);
    end

    // Held empty: narrow counter must stick at 15 while the wide one keeps counting.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 64'h0);
      #1;
      chk($sformatf("sat%0d_bub2", k), bub2, bmod2);
      chk($sformatf("sat%0d_bub1", k), bub1, bmod1);
      bump(1'b0);
    end
    chk("sat_final_bub2", bub2, 15);

    // Reset in the middle of a transfer drops both held entries.
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 64'h500);
    #1;
    chk("rx_occ0", occ1, 0);
    bump(1'b0);
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 64'h504);
    #1;
    chk("rx_occ1", occ1, 1);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 64'h0);
    #1;
    chk("rx_occ2", occ1, 2);
    chk("rx_pc_held", out_pc1, 64'h500);
    bmod1 = 0;
    bmod2 = 0;
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 64'h0);
    #1;
    chk("rst_ov1",  out_valid1, 0);
    chk("rst_occ1", occ1, 0);
    chk("rst_pc1",  out_pc1, 0);
    chk("rst_dat1", out_data1, 0);
    chk("rst_bub1", bub1, bmod1);
    chk("rst_occ2", occ2, 0);
    chk("rst_dat2", out_data2, 0);
    chk("rst_bub2", bub2, bmod2);
    bump(1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rst_cnt%0d_bub1", k), bub1, bmod1);
      chk($sformatf("rst_cnt%0d_bub2", k), bub2, bmod2);
      bump(1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
